dm_access_ctrl: RTL
===================

Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory (RAM) interface: takes RV32I load/store requests from the core's MEM stage and drives the word-addressed 64x32 RAM port (Men_Write, DM_Addr, M_W_Data, M_R_Data).
- Handles LB/LH/LW/LBU/LHU/SB/SH/SW:
  - byte/halfword stores via read-modify-write;
  - loads via lane extract plus sign/zero extension.
- Reports misaligned and out-of-range accesses.

Parameters:
- ADDR_W, 6, RAM word-address width (RAM depth = 2^ADDR_W words)
- DATA_W, 32, data width; fixed at 32, not to be overridden

Ports:
- clk_dm  in  1  clock shared with RAM; all state on rising edge
- rst_dm  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range; valid with rsp_valid
- Men_Write  out  1  RAM write enable; RAM writes on rising clk_dm
- DM_Addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2]
- M_W_Data  out  32  RAM write data
- M_R_Data  in  32  RAM read data, combinational on DM_Addr

Behaviour:
- Reset (async, rst_dm=1):
  - state=IDLE;
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - Men_Write=0, DM_Addr=0, M_W_Data=0.
- Reset mid-operation aborts. Men_Write drops immediately, so no partial write can complete after reset asserts.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, we, funct3 and wdata, then go to:
    - RESP with err=1 if the access is invalid;
    - WRITE for SW;
    - READ for all other accesses.
- READ:
  - Drive DM_Addr from the latched address and capture M_R_Data at the clock edge.
  - Next state: RESP for a load; WRITE for SB/SH.
- WRITE:
  - Drive Men_Write=1 for exactly one cycle.
  - M_W_Data is either wdata (SW) or the captured word with the selected byte/halfword lane replaced by wdata[7:0]/[15:0].
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for one cycle; req_ready=0.
  - rsp_rdata:
    - load: the lane selected by addr[1:0], sign-extended for B/H, zero-extended for BU/HU;
    - store or error: 0.
  - Next state: IDLE.
- req_ready is 1 only in IDLE. Requests presented in other states are ignored, not queued.
- Latency from the accept edge to rsp_valid high:
  - LW/LB/LH: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- Invalid access (rsp_err=1, no RAM write):
  - req_addr[31:ADDR_W+2] != 0 (out of range);
  - funct3 011, 110 or 111 (unsupported);
  - misaligned access (gated by the optional feature below).
- Lane placement: byte lane = addr[1:0]; halfword lane = addr[1].
- Men_Write is never asserted outside WRITE. DM_Addr holds its last value in IDLE.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, gives rsp_err=1, 1-cycle latency and no RAM access.
- Undefined: low address bits are forced aligned (H clears addr[0], W clears addr[1:0]). The access proceeds normally with rsp_err=0; out-of-range and unsupported-funct3 checks still apply.

Decomposition:
- Package dm_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding (IDLE, READ, WRITE, RESP);
  - DATA_W.
- One combinational sub-module, dm_byte_lane, provides store merge (word, wdata, addr[1:0], size -> merged word) and load extract (word, addr[1:0], funct3 -> extended data).
- The FSM stays in dm_access_ctrl.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF -> Men_Write high one cycle with DM_Addr=4 and M_W_Data=0xDEADBEEF; rsp_valid 2 cycles after accept; rsp_err=0.
- After that, LB addr 0x13 -> rsp_rdata=0xFFFFFFDE; LBU addr 0x13 -> 0x000000DE; LH addr 0x10 -> 0xFFFFBEEF.
- SB addr 0x11, wdata 0x55 -> READ then WRITE with M_W_Data=0xDEAD55EF; LW addr 0x10 -> 0xDEAD55EF; latency 3 cycles.
- LW addr 0x100 -> rsp_err=1 and rsp_rdata=0 one cycle after accept; Men_Write stays 0 throughout.
- LH addr 0x11:
  - with DM_MISALIGN_TRAP_EN: rsp_err=1;
  - without: reads 0x10 and returns 0x000055EF, err=0.
- Assert rst_dm during the WRITE state of an SB -> Men_Write=0 immediately; the word at DM_Addr 4 is unchanged when read back; req_ready=1 after reset releases.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, funct3 codes and FSM state encoding for the data-memory access controller
package dm_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] doubles as the access size code
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dm_state_t;

  // Only the five RV32I load/store widths are legal; 011, 110 and 111 are rejected.
  function automatic logic f3_supported(input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// rtl/dm_byte_lane.sv - combinational store-merge and load-extract for byte/halfword lanes
module dm_byte_lane
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] extracted
);

  logic [4:0] byte_base;
  logic [4:0] half_base;
  logic [7:0] byte_val;
  logic [15:0] half_val;

  // Bit offsets of the addressed byte lane and halfword lane within the word.
  assign byte_base = {lane, 3'b000};
  assign half_base = {lane[1], 4'b0000};
  assign byte_val  = word[byte_base +: 8];
  assign half_val  = word[half_base +: 16];

  // Store merge: replace only the addressed lane of the previously read word.
  always_comb begin
    merged = word;
    case (size)
      SZ_B:    merged[byte_base +: 8]  = wdata[7:0];
      SZ_H:    merged[half_base +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  // Load extract: pick the lane and sign- or zero-extend it to the full word.
  always_comb begin
    extracted = word;
    case (funct3)
      F3_B:    extracted = {{24{byte_val[7]}}, byte_val};
      F3_BU:   extracted = {24'd0, byte_val};
      F3_H:    extracted = {{16{half_val[15]}}, half_val};
      F3_HU:   extracted = {16'd0, half_val};
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - RV32I load/store initiator for a word-addressed RAM; build option DM_MISALIGN_TRAP_EN
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk_dm,
  input  logic              rst_dm,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Men_Write,
  output logic [ADDR_W-1:0] DM_Addr,
  input  logic [DATA_W-1:0] M_R_Data,
  output logic [DATA_W-1:0] M_W_Data
);

  dm_state_t         state;
  dm_state_t         state_nxt;

  logic [ADDR_W-1:0] dm_addr_q;
  logic [1:0]        lane_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rword_q;
  logic              err_q;

  logic              accept;
  logic              out_of_range;
  logic              unsupported;
  logic              req_bad;
  logic [1:0]        eff_lo;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] extracted;

  assign accept       = (state == IDLE) && req_valid;
  assign out_of_range = |req_addr[31:ADDR_W+2];
  assign unsupported  = !f3_supported(req_funct3);

  // Low address bits after forcing natural alignment; a legal aligned access is unchanged.
  always_comb begin
    eff_lo = req_addr[1:0];
    case (req_funct3[1:0])
      SZ_H:    eff_lo = {req_addr[1], 1'b0};
      SZ_W:    eff_lo = 2'b00;
      default: eff_lo = req_addr[1:0];
    endcase
  end

`ifdef DM_MISALIGN_TRAP_EN
  logic misaligned;

  // Misaligned halfword/word accesses are reported as errors instead of being aligned.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_bad = out_of_range || unsupported || misaligned;
`else
  assign req_bad = out_of_range || unsupported;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk_dm or posedge rst_dm) begin
    if (rst_dm) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture at accept and RAM word capture in READ.
  always_ff @(posedge clk_dm or posedge rst_dm) begin
    if (rst_dm) begin
      dm_addr_q <= '0;
      lane_q    <= 2'b00;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      wdata_q   <= '0;
      rword_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lane_q  <= eff_lo;
        we_q    <= req_we;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
        // Rejected requests never touch the RAM, so the address port keeps its old value.
        if (!req_bad) begin
          dm_addr_q <= req_addr[ADDR_W+1:2];
        end
      end
      if (state == READ) begin
        rword_q <= M_R_Data;
      end
    end
  end

  // Next-state logic and the handshake/RAM strobes, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    Men_Write = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad) begin
            state_nxt = RESP;
          end else if (req_we && (req_funct3[1:0] == SZ_W)) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        state_nxt = we_q ? WRITE : RESP;
      end
      WRITE: begin
        Men_Write = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  dm_byte_lane u_byte_lane (
    .word      (rword_q),
    .wdata     (wdata_q),
    .lane      (lane_q),
    .size      (f3_q[1:0]),
    .funct3    (f3_q),
    .merged    (merged),
    .extracted (extracted)
  );

  // Data outputs are zero outside the cycle in which they are meaningful.
  always_comb begin
    M_W_Data  = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state == WRITE) begin
      M_W_Data = merged;
    end
    if (state == RESP) begin
      rsp_err = err_q;
      if (!we_q && !err_q) begin
        rsp_rdata = extracted;
      end
    end
  end

  assign DM_Addr = dm_addr_q;

endmodule
